// File: rtl/gshare_predictor_pkg.sv
// gshare_predictor_pkg: default gshare sizing, the fetch-to-execute prediction bundle
// and the history/PC index hash shared by the predictor and its users.
package gshare_predictor_pkg;

    localparam int GSHARE_CFG_GHSR_W      = 10;
    localparam int GSHARE_CFG_PHT_ENTRIES = 1024;

    typedef struct packed {
        logic                         taken;
        logic [GSHARE_CFG_GHSR_W-1:0] ghsr;
    } gshare_pred_t;

    // Bit i of the history lands on index bit i mod idx_w, which XORs successive
    // idx_w-wide slices together and zero-extends a history shorter than the index.
    function automatic logic [31:0] gshare_hash(
        input logic [63:0] ghsr,
        input logic [63:0] pc,
        input int          ghsr_w,
        input int          idx_w
    );
        logic [31:0] h;
        h = '0;
        for (int i = 0; i < 64; i++)
            if (i < ghsr_w) h[5'(i % idx_w)] ^= ghsr[6'(i)];
        for (int j = 0; j < 32; j++)
            if (j < idx_w) h[5'(j)] ^= pc[6'(j + 2)];
        return h;
    endfunction

endpackage

// File: rtl/gshare_predictor_sat_counter_table.sv
// sat_counter_table: pattern history table of saturating counters with a one-entry-per-cycle
// initialisation sweep after reset and a single read-modify-write training port.
module sat_counter_table #(
    parameter int                   ENTRIES   = 1024,
    parameter int                   IDX_W     = $clog2(ENTRIES),
    parameter int                   CTR_WIDTH = 2,
    parameter logic [CTR_WIDTH-1:0] CTR_INIT  = CTR_WIDTH'(1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [IDX_W-1:0]     i_rd_idx,
    output logic [CTR_WIDTH-1:0] o_rd_ctr,
    input  logic                 i_wr_en,
    input  logic [IDX_W-1:0]     i_wr_idx,
    input  logic                 i_wr_taken,
    output logic                 o_busy
);

    localparam logic [0:0] INIT  = 1'b0;
    localparam logic [0:0] READY = 1'b1;

    logic [0:0]           r_state;
    logic [IDX_W-1:0]     r_ptr;
    logic [CTR_WIDTH-1:0] r_pht [ENTRIES];
    logic [CTR_WIDTH-1:0] w_cur;
    logic [CTR_WIDTH-1:0] w_next;
    logic                 w_busy;

    assign w_busy   = (r_state == INIT);
    assign w_cur    = r_pht[i_wr_idx];
    assign o_rd_ctr = r_pht[i_rd_idx];
    assign o_busy   = w_busy;

    always_comb
        w_next = i_wr_taken ? ((&w_cur) ? w_cur : w_cur + 1'b1)
                            : ((|w_cur) ? w_cur - 1'b1 : w_cur);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= INIT;
            r_ptr   <= '0;
        end else if (w_busy) begin
            r_ptr <= r_ptr + 1'b1;
            if (r_ptr == IDX_W'(ENTRIES - 1)) r_state <= READY;
        end
    end

    // Storage is not reset: the sweep overwrites every entry before training is allowed.
    always_ff @(posedge clk) begin
        if (w_busy)
            r_pht[r_ptr] <= CTR_INIT;
        else if (i_wr_en)
            r_pht[i_wr_idx] <= w_next;
    end

endmodule

// File: rtl/gshare_predictor.sv
// gshare_predictor: fetch-stage direction predictor indexing a counter table with
// speculative global history XOR PC, with history recovery from execute on a mispredict.
module gshare_predictor
    import gshare_predictor_pkg::*;
#(
    parameter int                   XLEN        = 32,
    parameter int                   GHSR_WIDTH  = GSHARE_CFG_GHSR_W,
    parameter int                   PHT_ENTRIES = GSHARE_CFG_PHT_ENTRIES,
    parameter int                   CTR_WIDTH   = 2,
    parameter logic [CTR_WIDTH-1:0] CTR_INIT    = CTR_WIDTH'(1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  lookup_valid,
    input  logic [XLEN-1:0]       lookup_pc,
    output logic                  predict_taken,
    output logic [GHSR_WIDTH-1:0] predict_ghsr,
    output logic                  busy,
    input  logic                  update_valid,
    input  logic [XLEN-1:0]       update_pc,
    input  logic [GHSR_WIDTH-1:0] update_ghsr,
    input  logic                  update_taken,
    input  logic                  update_mispredict
);

    localparam int PHT_IDX_W = $clog2(PHT_ENTRIES);

    logic [GHSR_WIDTH-1:0] r_ghsr;
    logic [GHSR_WIDTH-1:0] w_spec;
    logic [GHSR_WIDTH-1:0] w_rec;
    logic [PHT_IDX_W-1:0]  w_rd_idx;
    logic [PHT_IDX_W-1:0]  w_wr_idx;
    logic [CTR_WIDTH-1:0]  w_rd_ctr;
    logic                  w_busy;

    assign w_rd_idx = PHT_IDX_W'(gshare_hash(64'(r_ghsr), 64'(lookup_pc), GHSR_WIDTH, PHT_IDX_W));
    assign w_wr_idx = PHT_IDX_W'(gshare_hash(64'(update_ghsr), 64'(update_pc), GHSR_WIDTH, PHT_IDX_W));

    assign predict_taken = !w_busy && w_rd_ctr[CTR_WIDTH-1];
    assign predict_ghsr  = w_busy ? '0 : r_ghsr;
    assign busy          = w_busy;

    // Truncating the concatenation keeps the shift legal when the history is one bit wide.
    assign w_spec = GHSR_WIDTH'({r_ghsr, predict_taken});
    assign w_rec  = GHSR_WIDTH'({update_ghsr, update_taken});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_ghsr <= '0;
        else if (!w_busy) begin
            if (update_valid && update_mispredict)
                r_ghsr <= w_rec;
            else if (lookup_valid)
                r_ghsr <= w_spec;
        end
    end

    sat_counter_table #(
        .ENTRIES   (PHT_ENTRIES),
        .IDX_W     (PHT_IDX_W),
        .CTR_WIDTH (CTR_WIDTH),
        .CTR_INIT  (CTR_INIT)
    ) u_table (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_rd_idx   (w_rd_idx),
        .o_rd_ctr   (w_rd_ctr),
        .i_wr_en    (update_valid),
        .i_wr_idx   (w_wr_idx),
        .i_wr_taken (update_taken),
        .o_busy     (w_busy)
    );

endmodule

// File: tb/tb_gshare_predictor.sv
// tb_gshare_predictor: directed stimulus with an array-based model of the predictor checked
// every cycle, plus hand-computed expectations for init length, saturation and recovery.
module tb_gshare_predictor;

    localparam int GH = 10;
    localparam int N  = 1024;
    localparam int IW = 10;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          lookup_valid = 1'b0;
    logic [31:0]   lookup_pc = '0;
    logic          predict_taken;
    logic [GH-1:0] predict_ghsr;
    logic          busy;
    logic          update_valid = 1'b0;
    logic [31:0]   update_pc = '0;
    logic [GH-1:0] update_ghsr = '0;
    logic          update_taken = 1'b0;
    logic          update_mispredict = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    int m_pht [N];
    int m_ghsr = 0;
    int m_cnt  = 0;
    int m_pt, m_ui, e_pt, e_pg, busy_n;
    logic e_busy;

    gshare_predictor dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .lookup_valid      (lookup_valid),
        .lookup_pc         (lookup_pc),
        .predict_taken     (predict_taken),
        .predict_ghsr      (predict_ghsr),
        .busy              (busy),
        .update_valid      (update_valid),
        .update_pc         (update_pc),
        .update_ghsr       (update_ghsr),
        .update_taken      (update_taken),
        .update_mispredict (update_mispredict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int m_idx(input int g, input int pc);
        int h = 0;
        while (g != 0) begin
            h ^= g & (N - 1);
            g = g >> IW;
        end
        return h ^ ((pc >> 2) & (N - 1));
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_cnt  = 0;
            m_ghsr = 0;
        end else if (m_cnt < N) begin
            m_cnt++;
            if (m_cnt == N) for (int i = 0; i < N; i++) m_pht[i] = 1;
        end else begin
            m_pt = (m_pht[m_idx(m_ghsr, int'(lookup_pc))] >= 2) ? 1 : 0;
            if (update_valid) begin
                m_ui = m_idx(int'(update_ghsr), int'(update_pc));
                if (update_taken) m_pht[m_ui] = (m_pht[m_ui] == 3) ? 3 : m_pht[m_ui] + 1;
                else              m_pht[m_ui] = (m_pht[m_ui] == 0) ? 0 : m_pht[m_ui] - 1;
            end
            if (update_valid && update_mispredict)
                m_ghsr = ((int'(update_ghsr) << 1) | int'(update_taken)) & ((1 << GH) - 1);
            else if (lookup_valid)
                m_ghsr = ((m_ghsr << 1) | m_pt) & ((1 << GH) - 1);
        end
    end

    always @(negedge clk) begin
        e_busy = !reset_n || (m_cnt < N);
        e_pt   = e_busy ? 0 : ((m_pht[m_idx(m_ghsr, int'(lookup_pc))] >= 2) ? 1 : 0);
        e_pg   = e_busy ? 0 : m_ghsr;
        chk("model_busy", 32'(busy), 32'(e_busy));
        chk("model_predict_taken", 32'(predict_taken), e_pt);
        chk("model_predict_ghsr", 32'(predict_ghsr), e_pg);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic upd(input logic [31:0] pc, input logic [GH-1:0] g, input logic t, input logic m);
        step();
        update_valid      = 1'b1;
        update_pc         = pc;
        update_ghsr       = g;
        update_taken      = t;
        update_mispredict = m;
        step();
        update_valid      = 1'b0;
        update_mispredict = 1'b0;
    endtask

    // Counts sampled cycles with busy high while hammering the ignored inputs.
    task automatic count_busy(output int n);
        n = 0;
        for (int k = 0; k < 3000; k++) begin
            #1;
            if (!busy) break;
            n++;
            lookup_valid      = (k % 2 == 1);
            lookup_pc         = 32'h100;
            update_valid      = (k % 3 == 0);
            update_pc         = 32'h100;
            update_ghsr       = GH'(k);
            update_taken      = 1'b1;
            update_mispredict = (k % 5 == 0);
            step();
        end
        lookup_valid      = 1'b0;
        update_valid      = 1'b0;
        update_mispredict = 1'b0;
        update_ghsr       = '0;
    endtask

    initial begin
        repeat (3) step();
        #1;
        chk("reset_busy", 32'(busy), 1);
        chk("reset_pt", 32'(predict_taken), 0);
        chk("reset_pg", 32'(predict_ghsr), 0);
        step();
        reset_n = 1'b1;
        count_busy(busy_n);
        chk("init_len", busy_n, 1024);
        for (int i = 0; i < N; i++) begin
            step();
            lookup_pc = 32'(i << 2);
            #1;
            chk("init_entry", 32'(predict_taken), 0);
        end
        lookup_pc = 32'h100;
        step();
        update_valid = 1'b1;
        update_pc    = 32'h100;
        update_ghsr  = '0;
        update_taken = 1'b1;
        #1;
        chk("same_cycle_pre_update", 32'(predict_taken), 0);
        step();
        update_valid = 1'b0;
        #1;
        chk("ctr_10", 32'(predict_taken), 1);
        upd(32'h100, '0, 1'b1, 1'b0);
        upd(32'h100, '0, 1'b1, 1'b0);
        #1;
        chk("ctr_sat_11", 32'(predict_taken), 1);
        upd(32'h100, '0, 1'b0, 1'b0);
        #1;
        chk("ctr_11_dec", 32'(predict_taken), 1);
        upd(32'h100, '0, 1'b0, 1'b0);
        #1;
        chk("ctr_back_01", 32'(predict_taken), 0);
        upd(32'h8, '0, 1'b1, 1'b0);
        step();
        lookup_valid = 1'b1;
        lookup_pc    = 32'h0;
        #1;
        chk("lk0_pt", 32'(predict_taken), 0);
        chk("lk0_pg", 32'(predict_ghsr), 0);
        step();
        lookup_pc = 32'h4;
        #1;
        chk("lk1_pt", 32'(predict_taken), 0);
        chk("lk1_pg", 32'(predict_ghsr), 0);
        step();
        lookup_pc = 32'h8;
        #1;
        chk("lk2_pt", 32'(predict_taken), 1);
        chk("lk2_pg", 32'(predict_ghsr), 0);
        step();
        lookup_valid = 1'b0;
        #1;
        chk("ghsr_after_lk", 32'(predict_ghsr), 32'h001);
        step();
        lookup_valid      = 1'b1;
        update_valid      = 1'b1;
        update_mispredict = 1'b1;
        update_ghsr       = 10'h155;
        update_taken      = 1'b1;
        update_pc         = 32'h200;
        step();
        lookup_valid      = 1'b0;
        update_valid      = 1'b0;
        update_mispredict = 1'b0;
        #1;
        chk("recover_ghsr", 32'(predict_ghsr), 32'h2AB);
        upd(32'h4, '0, 1'b0, 1'b1);
        #1;
        chk("recover_zero", 32'(predict_ghsr), 0);
        lookup_pc = 32'h0;
        repeat (4) upd(32'h0, '0, 1'b0, 1'b0);
        #1;
        chk("ctr_floor", 32'(predict_taken), 0);
        upd(32'h0, '0, 1'b1, 1'b0);
        #1;
        chk("ctr_no_wrap", 32'(predict_taken), 0);
        upd(32'h0, '0, 1'b1, 1'b0);
        #1;
        chk("ctr_floor_up2", 32'(predict_taken), 1);
        step();
        lookup_valid = 1'b1;
        step();
        lookup_valid = 1'b0;
        #1;
        chk("ghsr_pre_reset", 32'(predict_ghsr), 1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy), 1);
        chk("async_rst_pg", 32'(predict_ghsr), 0);
        step();
        reset_n = 1'b1;
        repeat (500) step();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        count_busy(busy_n);
        chk("reinit_len", busy_n, 1024);
        lookup_pc = 32'h100;
        #1;
        chk("reinit_idx40", 32'(predict_taken), 0);
        chk("reinit_pg", 32'(predict_ghsr), 0);
        lookup_pc = 32'h0;
        #1;
        chk("reinit_idx0", 32'(predict_taken), 0);
        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
